// File: rtl/random_control_multi_if.sv
// Stimulus/config bundle for random_control_multi.
// The master side drives configuration and partner signals; the slave side is the generator.
interface random_control_multi_if #(
  parameter int NCH   = 4,
  parameter int CNT_W = 16
);
  localparam int CH_W = (NCH > 32'd1) ? $clog2(NCH) : 32'd1;

  logic                 cfg_wr;
  logic [CH_W-1:0]      cfg_ch;
  logic                 cfg_var;
  logic [6:0]           cfg_min;
  logic [6:0]           cfg_max;
  logic [CNT_W-1:0]     cfg_step;
  logic                 cfg_sticky;
  logic [6:0]           cfg_burst;
  logic [NCH-1:0]       start;
  logic [CNT_W-1:0]     start_count;
  logic [NCH-1:0]       stop;
  logic [NCH-1:0]       control_in;
  logic [NCH-1:0]       control_out;
  logic [NCH-1:0]       busy;
  logic [NCH-1:0]       done;
  logic [NCH*CNT_W-1:0] hs_count;

  modport master (
    output cfg_wr, cfg_ch, cfg_var, cfg_min, cfg_max, cfg_step, cfg_sticky, cfg_burst,
    output start, start_count, stop, control_in,
    input  control_out, busy, done, hs_count
  );

  modport slave (
    input  cfg_wr, cfg_ch, cfg_var, cfg_min, cfg_max, cfg_step, cfg_sticky, cfg_burst,
    input  start, start_count, stop, control_in,
    output control_out, busy, done, hs_count
  );
endinterface

// File: rtl/random_control_multi.sv
// N-channel LFSR-driven random vld/rdy generator with constant or triangle-swept rate.
// Optional handshake statistics are built when RANDOM_CONTROL_MULTI_STATS_EN is defined.
module random_control_multi #(
  parameter int          NCH       = 4,
  parameter int          CNT_W     = 16,
  parameter logic [15:0] SEED      = 16'hACE1,
  parameter int unsigned BURST_DEF = 32'd10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  random_control_multi_if.slave bus
);
  localparam int CH_W = (NCH > 32'd1) ? $clog2(NCH) : 32'd1;

  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  function automatic logic [6:0] sat100(input logic [6:0] v);
    return (v > 7'd100) ? 7'd100 : v;
  endfunction

  function automatic logic [6:0] midpoint(input logic [6:0] a, input logic [6:0] b);
    return 7'(({1'b0, a} + {1'b0, b}) >> 1);
  endfunction

  logic [NCH-1:0]       out_v_s;
  logic [NCH-1:0]       busy_v_s;
  logic [NCH-1:0]       done_v_s;
  logic [NCH*CNT_W-1:0] hs_v_s;

  assign bus.control_out = out_v_s;
  assign bus.busy        = busy_v_s;
  assign bus.done        = done_v_s;
  assign bus.hs_count    = hs_v_s;

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    localparam logic [15:0] SEED_X = SEED ^ 16'(i * 32'h9E37);
    localparam logic [15:0] SEED_I = (SEED_X == 16'h0000) ? 16'h0001 : SEED_X;

    state_t           state_r;
    logic [15:0]      lfsr_r;
    logic [6:0]       rate_r;
    logic [6:0]       min_r;
    logic [6:0]       max_r;
    logic [6:0]       burst_r;
    logic             dir_up_r;
    logic             var_r;
    logic             sticky_r;
    logic             out_r;
    logic             done_r;
    logic [CNT_W-1:0] step_r;
    logic [CNT_W-1:0] step_cnt_r;
    logic [CNT_W-1:0] remain_r;

    logic             run_s;
    logic             sel_s;
    logic             hs_s;
    logic             famine_s;
    logic             burst_s;
    logic             out_nxt_s;
    logic             step_hit_s;
    logic             eff_up_s;
    logic             nxt_var_s;
    logic [6:0]       min_in_s;
    logic [6:0]       max_in_s;
    logic [6:0]       nxt_min_s;
    logic [6:0]       nxt_max_s;
    logic [6:0]       init_rate_s;
    logic [6:0]       r_s;
    logic [6:0]       rate_sw_s;
    logic [15:0]      lfsr_nxt_s;

    assign run_s     = (state_r == ST_RUN);
    assign sel_s     = bus.cfg_wr & (bus.cfg_ch == CH_W'(i));
    assign min_in_s  = sat100(bus.cfg_min);
    assign max_in_s  = (sat100(bus.cfg_max) < min_in_s) ? min_in_s : sat100(bus.cfg_max);

    // A start coinciding with a config write initialises from the new config.
    assign nxt_var_s   = sel_s ? bus.cfg_var : var_r;
    assign nxt_min_s   = sel_s ? min_in_s    : min_r;
    assign nxt_max_s   = sel_s ? max_in_s    : max_r;
    assign init_rate_s = nxt_var_s ? midpoint(nxt_min_s, nxt_max_s) : nxt_min_s;

    assign hs_s       = run_s & bus.control_in[i] & out_r;
    assign r_s        = 7'((32'(lfsr_r) * 32'd100) >> 16);
    assign famine_s   = var_r & (rate_r <= burst_r);
    assign burst_s    = var_r & ((7'd100 - rate_r) <= burst_r);
    assign out_nxt_s  = ((r_s < rate_r) & ~famine_s) | burst_s
                      | (sticky_r & out_r & ~bus.control_in[i]);
    assign lfsr_nxt_s = {1'b0, lfsr_r[15:1]} ^ (lfsr_r[0] ? 16'hB400 : 16'h0000);

    // Step period of 0 behaves like 1.
    assign step_hit_s = (step_r <= CNT_W'(1)) | (step_cnt_r == (step_r - CNT_W'(1)));
    assign eff_up_s   = (rate_r >= max_r) ? 1'b0 : ((rate_r <= min_r) ? 1'b1 : dir_up_r);
    assign rate_sw_s  = (min_r == max_r) ? min_r
                      : (eff_up_s ? (rate_r + 7'd1) : (rate_r - 7'd1));

    // Channel FSM, rate sweep, LFSR and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r    <= ST_IDLE;
        lfsr_r     <= SEED_I;
        rate_r     <= 7'd0;
        min_r      <= 7'd0;
        max_r      <= 7'd0;
        burst_r    <= 7'(BURST_DEF);
        dir_up_r   <= 1'b1;
        var_r      <= 1'b0;
        sticky_r   <= 1'b0;
        out_r      <= 1'b0;
        done_r     <= 1'b0;
        step_r     <= CNT_W'(1);
        step_cnt_r <= '0;
        remain_r   <= '0;
      end else begin
        done_r <= 1'b0;
        if (sel_s) begin
          var_r    <= bus.cfg_var;
          min_r    <= min_in_s;
          max_r    <= max_in_s;
          step_r   <= bus.cfg_step;
          sticky_r <= bus.cfg_sticky;
          burst_r  <= sat100(bus.cfg_burst);
        end
        if (run_s) begin
          lfsr_r <= lfsr_nxt_s;
        end
        if (bus.stop[i]) begin
          state_r <= ST_IDLE;
          out_r   <= 1'b0;
        end else if (bus.start[i]) begin
          state_r    <= ST_RUN;
          remain_r   <= bus.start_count;
          rate_r     <= init_rate_s;
          dir_up_r   <= 1'b1;
          step_cnt_r <= '0;
          out_r      <= run_s ? out_nxt_s : 1'b0;
        end else if (run_s) begin
          if (hs_s && (remain_r == CNT_W'(1))) begin
            state_r  <= ST_IDLE;
            out_r    <= 1'b0;
            done_r   <= 1'b1;
            remain_r <= '0;
          end else begin
            if (hs_s && (remain_r != '0)) begin
              remain_r <= remain_r - CNT_W'(1);
            end
            out_r <= out_nxt_s;
            if (sel_s) begin
              rate_r     <= init_rate_s;
              dir_up_r   <= 1'b1;
              step_cnt_r <= '0;
            end else if (var_r) begin
              if (step_hit_s) begin
                step_cnt_r <= '0;
                rate_r     <= rate_sw_s;
                dir_up_r   <= eff_up_s;
              end else begin
                step_cnt_r <= step_cnt_r + CNT_W'(1);
              end
            end else begin
              step_cnt_r <= '0;
            end
          end
        end else begin
          out_r <= 1'b0;
        end
      end
    end

    assign out_v_s[i]  = out_r;
    assign busy_v_s[i] = run_s;
    assign done_v_s[i] = done_r;

`ifdef RANDOM_CONTROL_MULTI_STATS_EN
    logic [CNT_W-1:0] hs_cnt_r;

    // Handshakes since reset or the last start, wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        hs_cnt_r <= '0;
      end else if (bus.start[i]) begin
        hs_cnt_r <= '0;
      end else if (hs_s) begin
        hs_cnt_r <= hs_cnt_r + CNT_W'(1);
      end else begin
        hs_cnt_r <= hs_cnt_r;
      end
    end

    assign hs_v_s[i*CNT_W +: CNT_W] = hs_cnt_r;
`else
    assign hs_v_s[i*CNT_W +: CNT_W] = '0;
`endif
  end
endmodule
